// File: rtl/pinmux_pkg.sv
// -----------------------------------------------------------------------------
// pinmux_pkg
// Definitions shared by the pinmux configuration controller and the pinmux:
//   - register indices (reg_addr[4:2]) of the configuration register bank
//   - implemented width of MULTI_FUNC and its bit-field offsets
//   - byte-enable merge helper used for every writable register
// -----------------------------------------------------------------------------
package pinmux_pkg;

  // Implemented bits of MULTI_FUNC; bits above this are reserved and read 0.
  localparam int unsigned MF_BITS = 17;

  // Register index as decoded from reg_addr[4:2].
  typedef logic [2:0] reg_idx_t;

  localparam reg_idx_t GPIO_DIR     = 3'd0;
  localparam reg_idx_t MULTI_FUNC   = 3'd1;
  localparam reg_idx_t GPIO_OUT     = 3'd2;
  localparam reg_idx_t GPIO_IN      = 3'd3;
  localparam reg_idx_t INTR_STAT    = 3'd4;
  localparam reg_idx_t INTR_MASK    = 3'd5;
  localparam reg_idx_t INTR_POSEDGE = 3'd6;
  localparam reg_idx_t INTR_NEGEDGE = 3'd7;

  // MULTI_FUNC field layout, shared with the pinmux.
  localparam int unsigned MF_PWM_LSB     = 0;
  localparam int unsigned MF_PWM_W       = 6;
  localparam int unsigned MF_INT_LSB     = 6;
  localparam int unsigned MF_INT_W       = 2;
  localparam int unsigned MF_UART_LSB    = 8;
  localparam int unsigned MF_UART_W      = 2;
  localparam int unsigned MF_SPIM_BIT    = 10;
  localparam int unsigned MF_SPIM_CS_LSB = 11;
  localparam int unsigned MF_SPIM_CS_W   = 4;
  localparam int unsigned MF_I2CM_BIT    = 15;
  localparam int unsigned MF_USB_BIT     = 16;

  // Replace only the bytes selected by be with the matching bytes of wdata.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pinmux_cfg_ctrl_gpio_intr_det.sv
// -----------------------------------------------------------------------------
// gpio_intr_det
// Input side of the GPIO block: synchronises the pad inputs, detects enabled
// rising/falling edges, accumulates them in INTR_STAT (write-1-to-clear, set
// wins) and produces the registered combined interrupt.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pad_gpio_i      asynchronous pad data from the pinmux
//   posedge_en_i    INTR_POSEDGE register
//   negedge_en_i    INTR_NEGEDGE register
//   mask_i          INTR_MASK register
//   w1c_i           bits being cleared in INTR_STAT this cycle
//   gpio_in_s_o     synchronised pad data (GPIO_IN)
//   stat_o          INTR_STAT register
//   irq_o           |(INTR_STAT & INTR_MASK), registered
// -----------------------------------------------------------------------------
module gpio_intr_det
  import pinmux_pkg::*;
#(
  parameter int unsigned NBIT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBIT-1:0] pad_gpio_i,
  input  logic [NBIT-1:0] posedge_en_i,
  input  logic [NBIT-1:0] negedge_en_i,
  input  logic [NBIT-1:0] mask_i,
  input  logic [NBIT-1:0] w1c_i,
  output logic [NBIT-1:0] gpio_in_s_o,
  output logic [NBIT-1:0] stat_o,
  output logic            irq_o
);

  logic [NBIT-1:0] sync1_q;
  logic [NBIT-1:0] sync2_q;
  logic [NBIT-1:0] prev_q;
  logic [NBIT-1:0] stat_q, stat_d;
  logic [1:0]      warm_q, warm_d;
  logic            irq_q;
  logic            armed;
  logic [NBIT-1:0] pos_evt, neg_evt;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    warm_d  = warm_q;
    pos_evt = '0;
    neg_evt = '0;
    armed   = (warm_q == 2'd3);
    if (!armed) warm_d = warm_q + 2'd1;
    // Edges are ignored until the warm-up counter saturates, so pins that are
    // already high when reset is released do not look like rising edges.
    if (armed) begin
      pos_evt =  sync2_q & ~prev_q & posedge_en_i;
      neg_evt = ~sync2_q &  prev_q & negedge_en_i;
    end
    // New events override a clear of the same bit in the same cycle.
    stat_d = (stat_q & ~w1c_i) | pos_evt | neg_evt;
  end

  // NOTE: sequential state uses non-blocking assignments only, and the
  // synchroniser flops are reset too so GPIO_IN reads 0 straight after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
      stat_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= pad_gpio_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      warm_q  <= warm_d;
      stat_q  <= stat_d;
      irq_q   <= |(stat_q & mask_i);
    end
  end

  assign gpio_in_s_o = sync2_q;
  assign stat_o      = stat_q;
  assign irq_o       = irq_q;

endmodule

// File: rtl/pinmux_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// pinmux_cfg_ctrl
// Register bank between the bus decoder and the pinmux. Owns the pinmux
// configuration (GPIO direction, multi-function select, GPIO output) and the
// GPIO interrupt registers; every access completes with a one-cycle reg_ack
// the cycle after it is accepted.
// Ports:
//   mclk, h_reset_n      clock, asynchronous active-low reset
//   reg_cs/wr/addr/be/wdata   bus request (held until reg_ack)
//   reg_rdata, reg_ack   registered response; rdata is 0 when ack is 0
//   cfg_gpio_dir_sel     GPIO_DIR to pinmux
//   cfg_multi_func_sel   MULTI_FUNC to pinmux (reserved bits 0)
//   pad_gpio_out         GPIO_OUT to pinmux
//   pad_gpio_in          asynchronous pad data from pinmux
//   gpio_irq             combined level interrupt
// -----------------------------------------------------------------------------
module pinmux_cfg_ctrl
  import pinmux_pkg::*;
#(
  parameter int unsigned NBIT    = 32,
  parameter int unsigned MF_BITS = pinmux_pkg::MF_BITS
) (
  input  logic            mclk,
  input  logic            h_reset_n,
  input  logic            reg_cs,
  input  logic            reg_wr,
  input  logic [4:0]      reg_addr,
  input  logic [3:0]      reg_be,
  input  logic [31:0]     reg_wdata,
  output logic [31:0]     reg_rdata,
  output logic            reg_ack,
  output logic [NBIT-1:0] cfg_gpio_dir_sel,
  output logic [31:0]     cfg_multi_func_sel,
  output logic [NBIT-1:0] pad_gpio_out,
  input  logic [NBIT-1:0] pad_gpio_in,
  output logic            gpio_irq
);

  logic [NBIT-1:0]    dir_q,  dir_d;
  logic [MF_BITS-1:0] mf_q,   mf_d;
  logic [NBIT-1:0]    out_q,  out_d;
  logic [NBIT-1:0]    mask_q, mask_d;
  logic [NBIT-1:0]    pose_q, pose_d;
  logic [NBIT-1:0]    nege_q, nege_d;
  logic [NBIT-1:0]    w1c;
  logic [NBIT-1:0]    gpio_in_s;
  logic [NBIT-1:0]    stat;
  logic               ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        rd_mux;
  logic               accept;
  logic               wr_en;
  reg_idx_t           idx;
  logic               unused_addr;

  assign idx         = reg_addr[4:2];
  assign unused_addr = ^reg_addr[1:0];
  // A held request is taken once; the ack cycle itself never accepts, which
  // makes back-to-back requests complete every other cycle.
  assign accept      = reg_cs & ~ack_q;
  assign wr_en       = accept & reg_wr;

  always_comb begin
    dir_d  = dir_q;
    mf_d   = mf_q;
    out_d  = out_q;
    mask_d = mask_q;
    pose_d = pose_q;
    nege_d = nege_q;
    w1c    = '0;
    if (wr_en) begin
      case (idx)
        GPIO_DIR:     dir_d  = NBIT'(be_merge(32'(dir_q), reg_wdata, reg_be));
        MULTI_FUNC:   mf_d   = MF_BITS'(be_merge(32'(mf_q), reg_wdata, reg_be));
        GPIO_OUT:     out_d  = NBIT'(be_merge(32'(out_q), reg_wdata, reg_be));
        INTR_STAT:    w1c    = NBIT'(be_merge('0, reg_wdata, reg_be));
        INTR_MASK:    mask_d = NBIT'(be_merge(32'(mask_q), reg_wdata, reg_be));
        INTR_POSEDGE: pose_d = NBIT'(be_merge(32'(pose_q), reg_wdata, reg_be));
        INTR_NEGEDGE: nege_d = NBIT'(be_merge(32'(nege_q), reg_wdata, reg_be));
        default:      ; // GPIO_IN is read-only; the write still acks
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      GPIO_DIR:     rd_mux = 32'(dir_q);
      MULTI_FUNC:   rd_mux = 32'(mf_q);
      GPIO_OUT:     rd_mux = 32'(out_q);
      GPIO_IN:      rd_mux = 32'(gpio_in_s);
      INTR_STAT:    rd_mux = 32'(stat);
      INTR_MASK:    rd_mux = 32'(mask_q);
      INTR_POSEDGE: rd_mux = 32'(pose_q);
      INTR_NEGEDGE: rd_mux = 32'(nege_q);
      default:      rd_mux = '0;
    endcase
    ack_d   = accept;
    rdata_d = (accept && !reg_wr) ? rd_mux : '0;
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      dir_q   <= '0;
      mf_q    <= '0;
      out_q   <= '0;
      mask_q  <= '0;
      pose_q  <= '0;
      nege_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      dir_q   <= dir_d;
      mf_q    <= mf_d;
      out_q   <= out_d;
      mask_q  <= mask_d;
      pose_q  <= pose_d;
      nege_q  <= nege_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  gpio_intr_det #(
    .NBIT (NBIT)
  ) u_intr_det (
    .clk          (mclk),
    .rst_n        (h_reset_n),
    .pad_gpio_i   (pad_gpio_in),
    .posedge_en_i (pose_q),
    .negedge_en_i (nege_q),
    .mask_i       (mask_q),
    .w1c_i        (w1c),
    .gpio_in_s_o  (gpio_in_s),
    .stat_o       (stat),
    .irq_o        (gpio_irq)
  );

  assign reg_ack            = ack_q;
  assign reg_rdata          = rdata_q;
  assign cfg_gpio_dir_sel   = dir_q;
  assign cfg_multi_func_sel = 32'(mf_q);
  assign pad_gpio_out       = out_q;

endmodule

// File: tb/tb_pinmux_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pinmux_cfg_ctrl
// Directed bench: a table of bus accesses with hand-computed read data and
// configuration outputs, then hand-written sequences for edge latency,
// set-wins-over-clear, masking, back-to-back requests and reset mid-access.
// -----------------------------------------------------------------------------
module tb_pinmux_cfg_ctrl;

  logic        mclk = 1'b0;
  logic        h_reset_n;
  logic        reg_cs;
  logic        reg_wr;
  logic [4:0]  reg_addr;
  logic [3:0]  reg_be;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic [31:0] cfg_gpio_dir_sel;
  logic [31:0] cfg_multi_func_sel;
  logic [31:0] pad_gpio_out;
  logic [31:0] pad_gpio_in;
  logic        gpio_irq;

  int n_vec  = 0;
  int n_fail = 0;

  pinmux_cfg_ctrl dut (
    .mclk               (mclk),
    .h_reset_n          (h_reset_n),
    .reg_cs             (reg_cs),
    .reg_wr             (reg_wr),
    .reg_addr           (reg_addr),
    .reg_be             (reg_be),
    .reg_wdata          (reg_wdata),
    .reg_rdata          (reg_rdata),
    .reg_ack            (reg_ack),
    .cfg_gpio_dir_sel   (cfg_gpio_dir_sel),
    .cfg_multi_func_sel (cfg_multi_func_sel),
    .pad_gpio_out       (pad_gpio_out),
    .pad_gpio_in        (pad_gpio_in),
    .gpio_irq           (gpio_irq)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic        wr;
    logic [2:0]  idx;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [31:0] exp_dir;
    logic [31:0] exp_mf;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[32];
  int   n_tab = 0;

  function automatic vec_t mk(logic wr, logic [2:0] idx, logic [3:0] be,
                              logic [31:0] wd, logic [31:0] exp_rd,
                              logic [31:0] exp_dir, logic [31:0] exp_mf,
                              logic [31:0] exp_out);
    vec_t v;
    v.wr = wr; v.idx = idx; v.be = be; v.wd = wd; v.exp_rd = exp_rd;
    v.exp_dir = exp_dir; v.exp_mf = exp_mf; v.exp_out = exp_out;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Present a request and hold it until reg_ack (bounded); returns at the
  // sample point of the ack cycle with reg_cs already dropped.
  task automatic bus(input logic wr, input logic [2:0] idx,
                     input logic [3:0] be, input logic [31:0] wd,
                     output logic [31:0] rd, output logic got);
    reg_cs = 1'b1; reg_wr = wr; reg_addr = {idx, 2'b00};
    reg_be = be; reg_wdata = wd;
    got = 1'b0; rd = '0;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (reg_ack) begin
        got = 1'b1;
        rd  = reg_rdata;
      end
    end
    reg_cs = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic wr_reg(input string name, input logic [2:0] idx,
                        input logic [31:0] wd);
    logic [31:0] rd;
    logic        got;
    bus(1'b1, idx, 4'hF, wd, rd, got);
    check({name, "_ack"}, 32'(got), 32'd1);
    tick();
  endtask

  task automatic rd_reg(input string name, input logic [2:0] idx,
                        input logic [31:0] exp);
    logic [31:0] rd;
    logic        got;
    bus(1'b0, idx, 4'hF, '0, rd, got);
    check({name, "_ack"}, 32'(got), 32'd1);
    check(name, rd, exp);
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    logic        got;
    logic [31:0] pat[3];
    int          acks;

    h_reset_n = 1'b0; reg_cs = 1'b0; reg_wr = 1'b0; reg_addr = '0;
    reg_be = '0; reg_wdata = '0;
    pad_gpio_in = 32'h0000_0001;   // bit0 already high at reset

    // ---------------- vector table ----------------
    for (int i = 0; i < 8; i++)
      vecs[n_tab++] = mk(1'b0, 3'(i), 4'hF, '0, (i == 3) ? 32'h1 : 32'h0, 0, 0, 0);
    vecs[n_tab++] = mk(1, 3'd1, 4'hF,   32'hFFFF_FFFF, 0, 0, 32'h0001_FFFF, 0);
    vecs[n_tab++] = mk(0, 3'd1, 4'hF,   0, 32'h0001_FFFF, 0, 32'h0001_FFFF, 0);
    vecs[n_tab++] = mk(1, 3'd1, 4'b0010, 0, 0, 0, 32'h0001_00FF, 0);
    vecs[n_tab++] = mk(0, 3'd1, 4'hF,   0, 32'h0001_00FF, 0, 32'h0001_00FF, 0);
    vecs[n_tab++] = mk(1, 3'd0, 4'b0101, 32'hA5A5_1234, 0, 32'h00A5_0034, 32'h0001_00FF, 0);
    vecs[n_tab++] = mk(1, 3'd0, 4'b1000, 32'hFF00_0000, 0, 32'hFFA5_0034, 32'h0001_00FF, 0);
    vecs[n_tab++] = mk(0, 3'd0, 4'hF,   0, 32'hFFA5_0034, 32'hFFA5_0034, 32'h0001_00FF, 0);
    vecs[n_tab++] = mk(1, 3'd2, 4'hF,   32'hDEAD_BEEF, 0, 32'hFFA5_0034, 32'h0001_00FF, 32'hDEAD_BEEF);
    vecs[n_tab++] = mk(1, 3'd3, 4'hF,   32'hFFFF_FFFF, 0, 32'hFFA5_0034, 32'h0001_00FF, 32'hDEAD_BEEF);
    vecs[n_tab++] = mk(0, 3'd3, 4'hF,   0, 32'h0000_0001, 32'hFFA5_0034, 32'h0001_00FF, 32'hDEAD_BEEF);
    vecs[n_tab++] = mk(1, 3'd5, 4'hF,   32'h0000_00F0, 0, 32'hFFA5_0034, 32'h0001_00FF, 32'hDEAD_BEEF);
    vecs[n_tab++] = mk(0, 3'd5, 4'hF,   0, 32'h0000_00F0, 32'hFFA5_0034, 32'h0001_00FF, 32'hDEAD_BEEF);
    vecs[n_tab++] = mk(1, 3'd6, 4'b1100, 32'h1234_5678, 0, 32'hFFA5_0034, 32'h0001_00FF, 32'hDEAD_BEEF);
    vecs[n_tab++] = mk(0, 3'd6, 4'hF,   0, 32'h1234_0000, 32'hFFA5_0034, 32'h0001_00FF, 32'hDEAD_BEEF);
    vecs[n_tab++] = mk(1, 3'd7, 4'b0011, 32'hCAFE_BABE, 0, 32'hFFA5_0034, 32'h0001_00FF, 32'hDEAD_BEEF);
    vecs[n_tab++] = mk(0, 3'd7, 4'hF,   0, 32'h0000_BABE, 32'hFFA5_0034, 32'h0001_00FF, 32'hDEAD_BEEF);
    vecs[n_tab++] = mk(1, 3'd5, 4'hF,   0, 0, 32'hFFA5_0034, 32'h0001_00FF, 32'hDEAD_BEEF);
    vecs[n_tab++] = mk(1, 3'd6, 4'hF,   0, 0, 32'hFFA5_0034, 32'h0001_00FF, 32'hDEAD_BEEF);
    vecs[n_tab++] = mk(1, 3'd7, 4'hF,   0, 0, 32'hFFA5_0034, 32'h0001_00FF, 32'hDEAD_BEEF);
    vecs[n_tab++] = mk(0, 3'd4, 4'hF,   0, 0, 32'hFFA5_0034, 32'h0001_00FF, 32'hDEAD_BEEF);

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_ack", 32'(reg_ack), 0);
    check("rst_rdata", reg_rdata, 0);
    check("rst_irq", 32'(gpio_irq), 0);
    check("rst_mf", cfg_multi_func_sel, 0);
    h_reset_n = 1'b1;
    tick();

    for (int i = 0; i < n_tab; i++) begin
      bus(vecs[i].wr, vecs[i].idx, vecs[i].be, vecs[i].wd, rd, got);
      check($sformatf("v%0d_ack", i), 32'(got), 32'd1);
      if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_dir", i), cfg_gpio_dir_sel, vecs[i].exp_dir);
      check($sformatf("v%0d_mf", i), cfg_multi_func_sel, vecs[i].exp_mf);
      check($sformatf("v%0d_out", i), pad_gpio_out, vecs[i].exp_out);
      tick();
      check($sformatf("v%0d_ack_pulse", i), 32'(reg_ack), 0);
      check($sformatf("v%0d_rdata_idle", i), reg_rdata, 0);
    end

    // ---------------- rising-edge latency ----------------
    wr_reg("en_pos", 3'd6, 32'h1);
    wr_reg("en_mask", 3'd5, 32'h1);
    pad_gpio_in = 32'h0;
    repeat (4) tick();
    rd_reg("stat_before", 3'd4, 32'h0);
    pad_gpio_in = 32'h1;
    tick(); tick(); tick();
    check("irq_lat3", 32'(gpio_irq), 0);
    tick();
    check("irq_lat4", 32'(gpio_irq), 1);
    rd_reg("stat_after_edge", 3'd4, 32'h1);
    rd_reg("gpio_in_hi", 3'd3, 32'h1);

    // ---------------- set wins over same-cycle clear ----------------
    pad_gpio_in = 32'h0;
    repeat (4) tick();
    pad_gpio_in = 32'h1;
    tick(); tick();                          // edge is now at the sync output
    bus(1'b1, 3'd4, 4'hF, 32'h1, rd, got);   // accepted in the pos-event cycle
    check("w1c_collide_ack", 32'(got), 1);
    tick();
    rd_reg("stat_set_wins", 3'd4, 32'h1);
    check("irq_set_wins", 32'(gpio_irq), 1);
    bus(1'b1, 3'd4, 4'hF, 32'h1, rd, got);
    check("w1c_ack", 32'(got), 1);
    check("irq_at_w1c_ack", 32'(gpio_irq), 1);
    tick();
    check("irq_after_w1c", 32'(gpio_irq), 0);
    rd_reg("stat_cleared", 3'd4, 32'h0);

    // ---------------- falling edge, masking ----------------
    wr_reg("en_neg", 3'd7, 32'h10);
    wr_reg("mask_b4", 3'd5, 32'h10);
    pad_gpio_in = 32'h11;
    repeat (4) tick();
    pad_gpio_in = 32'h01;
    repeat (5) tick();
    check("irq_neg", 32'(gpio_irq), 1);
    rd_reg("stat_neg", 3'd4, 32'h10);
    wr_reg("mask_off", 3'd5, 32'h0);
    check("irq_masked", 32'(gpio_irq), 0);
    rd_reg("stat_kept", 3'd4, 32'h10);
    bus(1'b1, 3'd5, 4'hF, 32'h10, rd, got);
    check("unmask_ack", 32'(got), 1);
    check("irq_at_unmask_ack", 32'(gpio_irq), 0);
    tick();
    check("irq_unmask", 32'(gpio_irq), 1);
    wr_reg("clr_b4", 3'd4, 32'h10);
    wr_reg("mask_clr", 3'd5, 32'h0);

    // ---------------- back-to-back with reg_cs held ----------------
    pat[0] = 32'h1111_0001; pat[1] = 32'h2222_0002; pat[2] = 32'h3333_0003;
    acks = 0;
    reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = {3'd2, 2'b00}; reg_be = 4'hF;
    for (int k = 0; k < 6; k++) begin
      reg_wdata = pat[k/2];
      tick();
      if (reg_ack) acks++;
      check($sformatf("b2b_ack%0d", k), 32'(reg_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) check($sformatf("b2b_out%0d", k), pad_gpio_out, pat[k/2]);
    end
    reg_cs = 1'b0; reg_wr = 1'b0;
    check("b2b_count", 32'(acks), 3);
    tick();

    // ---------------- reset in the accept cycle ----------------
    pad_gpio_in = 32'h1;
    reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = {3'd0, 2'b00};
    reg_be = 4'hF; reg_wdata = 32'h5555_5555;
    #2 h_reset_n = 1'b0;
    #1;
    check("rst_mid_dir", cfg_gpio_dir_sel, 0);
    check("rst_mid_ack", 32'(reg_ack), 0);
    tick();
    check("rst_mid_ack_edge", 32'(reg_ack), 0);
    check("rst_mid_dir_edge", cfg_gpio_dir_sel, 0);
    reg_cs = 1'b0; reg_wr = 1'b0;
    h_reset_n = 1'b1;
    // POSEDGE is enabled while the synchronised high pin first appears.
    bus(1'b1, 3'd6, 4'hF, 32'h1, rd, got);
    check("warm_en_ack", 32'(got), 1);
    repeat (5) tick();
    rd_reg("warm_stat", 3'd4, 32'h0);
    rd_reg("warm_gpio_in", 3'd3, 32'h1);
    check("warm_irq", 32'(gpio_irq), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pinmux_cfg_ctrl.md
Name: pinmux_cfg_ctrl

Overview:
Register-bank controller that configures and services the pinmux block from the system register bus.
- Holds the GPIO direction, multi-function select and GPIO output registers that drive the pinmux config inputs.
- Synchronises `pad_gpio_in` coming back from the pinmux.
- Generates per-bit maskable edge interrupts and one combined interrupt line.
- Sits between the bus decoder and the pinmux; it is the only writer of pinmux configuration.

Parameters:
- NBIT, 32: GPIO width; all per-bit registers are NBIT wide.
- MF_BITS, 17: implemented bits of MULTI_FUNC; higher bits are reserved, write-ignored and read 0.

Ports:
- mclk  in  1  system clock
- h_reset_n  in  1  asynchronous active-low reset
- reg_cs  in  1  access request; held until reg_ack
- reg_wr  in  1  1 = write, 0 = read
- reg_addr  in  5  byte address; [4:2] selects the register
- reg_be  in  4  byte enables for writes
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, valid while reg_ack=1
- reg_ack  out  1  one-cycle access completion
- cfg_gpio_dir_sel  out  32  to pinmux
- cfg_multi_func_sel  out  32  to pinmux
- pad_gpio_out  out  32  to pinmux
- pad_gpio_in  in  32  from pinmux (asynchronous pad data)
- gpio_irq  out  1  combined interrupt, level, registered

Behaviour:
- Reset (async, h_reset_n=0): every register and output is 0. This includes reg_ack, reg_rdata, the sync flops, the previous-sample register and gpio_irq.
- Register map, index = reg_addr[4:2]:
  - 0 GPIO_DIR, rw
  - 1 MULTI_FUNC, rw; bits [31:MF_BITS] read 0
  - 2 GPIO_OUT, rw
  - 3 GPIO_IN, ro (synchronised value)
  - 4 INTR_STAT, write-1-to-clear
  - 5 INTR_MASK, rw
  - 6 INTR_POSEDGE, rw
  - 7 INTR_NEGEDGE, rw
- Handshake:
  - A request is accepted in a cycle where reg_cs=1 and reg_ack=0.
  - reg_ack rises in the next cycle for exactly 1 cycle, so every access takes 2 cycles.
  - Back-to-back requests with reg_cs held high complete every other cycle.
  - A write updates the target register at the accept edge; the new value is visible at the outputs together with reg_ack.
  - Read data is registered from the value at the accept edge.
  - reg_rdata returns 0 whenever reg_ack=0.
- Byte enables: only bytes with reg_be[n]=1 are written. Writes to GPIO_IN are ignored, and the access still acks.
- Synchronisation: pad_gpio_in passes through a 2-flop synchroniser into gpio_in_s.
- Edge detection:
  - gpio_prev <= gpio_in_s every cycle.
  - pos = gpio_in_s & ~gpio_prev & INTR_POSEDGE
  - neg = ~gpio_in_s & gpio_prev & INTR_NEGEDGE
  - Both may be enabled on the same bit.
- Startup suppression: a 2-bit saturating warm-up counter starts after reset release. Edge events are ignored until it saturates at 3, so pins already high at reset do not fire.
- INTR_STAT: stat_next = (stat & ~w1c_mask) | pos | neg. A set and a clear on the same bit in the same cycle leaves the bit at 1 (set wins).
- gpio_irq <= |(INTR_STAT & INTR_MASK), registered.
- Latency from a pad edge (after warm-up):
  - GPIO_IN readable after 2 mclk
  - STAT bit set after 3 mclk
  - gpio_irq high after 4 mclk
- Masking: writing INTR_MASK does not clear STAT, and unmasking an already-pending bit raises gpio_irq 1 cycle later.
- Reset mid-access: the access is aborted, reg_ack stays 0, and the register returns to 0.

Decomposition:
- Package pinmux_pkg:
  - register index localparams: GPIO_DIR..INTR_NEGEDGE = 0..7
  - MF_BITS
  - typedef for the 3-bit register index
  - the bit-field offsets of MULTI_FUNC (pwm 5:0, int 7:6, uart 9:8, spim 10, spim_cs 14:11, i2cm 15, usb 16), shared with the pinmux.
- Sub-module gpio_intr_det: synchroniser, previous-sample register, warm-up counter, edge logic and STAT/irq generation. Its inputs are the edge/mask registers and the w1c vector.

Test Plan:
- Reset, then read all 8 registers → all return 0 with reg_ack a single 1-cycle pulse; gpio_irq=0.
- Write MULTI_FUNC=0xFFFF_FFFF with be=4'b1111, then read back → 0x0001_FFFF. Then write be=4'b0010 data=0 → reads back 0x0001_00FF, and cfg_multi_func_sel matches at ack.
- Drive pad_gpio_in=0x0000_0001 from reset → no STAT bit set. Then set POSEDGE=1, MASK=1 and toggle bit0 0→1 → STAT=0x1 3 cycles later, gpio_irq=1 on cycle 4.
- With STAT[0]=1, write STAT=0x1 in the same cycle as a new bit0 edge → STAT stays 0x1. Then a w1c with no edge → STAT=0 and gpio_irq falls 1 cycle later.
- Hold reg_cs=1 for 6 cycles with writes to GPIO_OUT → exactly 3 acks, on alternating cycles; pad_gpio_out follows each write.
- Assert h_reset_n=0 in the accept cycle of a GPIO_DIR write → reg_ack stays 0, cfg_gpio_dir_sel=0 immediately; after release, warm-up suppresses edges for 3 cycles.
